// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S memory geometry, key layout, FSM states and the S-memory request struct.
package rc4_pkg;
  localparam int S_DEPTH    = 256;
  localparam int KEY_LENGTH = 3;
  localparam int KEY_W      = 8;
  localparam int ADDR_W     = $clog2(S_DEPTH);
  localparam int KIDX_W     = $clog2(KEY_LENGTH);

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, WT_I, UPD_J, RD_J, WT_J, CAP_J, WR_I, WR_J, NEXT, DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  data;
    logic              wren;
  } s_req_t;
endpackage

// File: rtl/rc4_key_schedule_if.sv
// Control handshake plus S-memory port of the key scheduler; master is the scheduler side.
interface rc4_key_schedule_if;
  import rc4_pkg::*;

  logic                        start;
  logic [KEY_LENGTH*KEY_W-1:0] secret_key;
  logic                        finish;
  logic [ADDR_W-1:0]           s_address;
  logic [KEY_W-1:0]            s_data;
  logic                        s_wren;
  logic [KEY_W-1:0]            s_q;

  modport master (input start, secret_key, s_q, output finish, s_address, s_data, s_wren);
  modport slave  (output start, secret_key, s_q, input finish, s_address, s_data, s_wren);
endinterface

// File: rtl/rc4_key_byte_select.sv
// Picks key byte idx from the packed key (byte0 is the most significant); out-of-range idx gives 0.
module rc4_key_byte_select
  import rc4_pkg::*;
(
  input  logic [KEY_LENGTH*KEY_W-1:0] secret_key,
  input  logic [KIDX_W-1:0]           idx,
  output logic [KEY_W-1:0]            key_byte
);
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_LENGTH; b++)
      if (idx == KIDX_W'(b)) key_byte = secret_key[(KEY_LENGTH-1-b)*KEY_W +: KEY_W];
  end
endmodule

// File: rtl/rc4_key_schedule.sv
// RC4 key scheduler: fills S with the identity, then runs the KSA swap loop over a sync-read RAM.
module rc4_key_schedule
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rc4_key_schedule_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [KEY_W-1:0]  si_q, si_d, sj_q, sj_d;
  logic [KIDX_W-1:0] k_q, k_d;
  logic [KEY_W-1:0]  key_byte;
  s_req_t            req;
  logic              finish;

  rc4_key_byte_select u_ksel (
    .secret_key (bus.secret_key),
    .idx        (k_q),
    .key_byte   (key_byte)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
    req     = '0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        i_d     = '0;
        state_d = INIT;
      end
      INIT: begin
        req = '{addr: i_q, data: i_q, wren: 1'b1};
        i_d = i_q + 1'b1;
        if (i_q == ADDR_W'(S_DEPTH-1)) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = RD_I;
        end
      end
      // Address is held through the wait and capture cycles so the RAM output stays valid.
      RD_I: begin req.addr = i_q; state_d = WT_I; end
      WT_I: begin req.addr = i_q; state_d = UPD_J; end
      UPD_J: begin
        req.addr = i_q;
        si_d     = bus.s_q;
        j_d      = j_q + bus.s_q + key_byte;
        state_d  = RD_J;
      end
      RD_J: begin req.addr = j_q; state_d = WT_J; end
      WT_J: begin req.addr = j_q; state_d = CAP_J; end
      CAP_J: begin
        req.addr = j_q;
        sj_d     = bus.s_q;
        state_d  = WR_I;
      end
      WR_I: begin req = '{addr: i_q, data: sj_q, wren: 1'b1}; state_d = WR_J; end
      // When i==j this later write restores the original value, as RC4 requires.
      WR_J: begin req = '{addr: j_q, data: si_q, wren: 1'b1}; state_d = NEXT; end
      NEXT: begin
        if (i_q == ADDR_W'(S_DEPTH-1)) state_d = DONE;
        else begin
          i_d     = i_q + 1'b1;
          k_d     = (k_q == KIDX_W'(KEY_LENGTH-1)) ? '0 : k_q + 1'b1;
          state_d = RD_I;
        end
      end
      DONE: begin finish = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
    end
  end

  assign bus.s_address = req.addr;
  assign bus.s_data    = req.data;
  assign bus.s_wren    = req.wren;
  assign bus.finish    = finish;
endmodule
